// File: rtl/demux_serial_driver.sv
// Feeds the 1-to-4 demux: takes a word and channel over valid/ready, shifts the word out MSB-first
// with a steady select, pulses frame_done after the last bit, then idles for GAP cycles.
module demux_serial_driver #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       chan,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             demux_in,
  output logic [1:0]       demux_sel,
  output logic             frame_active,
  output logic             frame_done
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [3:0]      GapLast = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  cnt_q;
  logic [3:0]       gap_cnt_q;

  // The register drains to zero after WIDTH shifts, so its MSB is 0 outside SHIFT.
  assign demux_in = shreg_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      cnt_q        <= '0;
      gap_cnt_q    <= '0;
      req_ready    <= 1'b1;
      demux_sel    <= 2'd0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            shreg_q      <= data_in;
            demux_sel    <= chan;
            cnt_q        <= '0;
            req_ready    <= 1'b0;
            frame_active <= 1'b1;
            state_q      <= StShift;
          end
        end
        StShift: begin
          shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            frame_active <= 1'b0;
            frame_done   <= 1'b1;
            if (GAP > 0) begin
              gap_cnt_q <= '0;
              state_q   <= StGap;
            end else begin
              req_ready <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            req_ready <= 1'b1;
            state_q   <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/demux_serial_driver.md
Name: demux_serial_driver

Overview:
- Upstream feeder for the 1-to-4 demultiplexer (`demux1_4`).
- Accepts a parallel data word and a 2-bit channel address through a valid/ready handshake.
- Serialises the word MSB-first onto the demux data input while holding the demux select stable for the entire frame.
- Marks frame boundaries and enforces a programmable idle gap between frames, so downstream per-channel logic sees clean, separated frames.

Parameters:
- WIDTH, 8: bits per frame; legal range 2..32.
- GAP, 1: idle cycles after each frame before the next request is accepted; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to serialise; sampled only on acceptance.
- chan  input  2  target demux channel, 0..3; sampled only on acceptance.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept; high only in IDLE.
- demux_in  output  1  serial bit to demux `in`.
- demux_sel  output  2  channel to demux `sel`.
- frame_active  output  1  high while a data bit is on demux_in.
- frame_done  output  1  one-cycle pulse after the last bit of a frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Outputs under rst_n=0 (applied immediately, not on a clock edge):
  - req_ready=1.
  - demux_in=0, demux_sel=0.
  - frame_active=0, frame_done=0.
  - Internal state=IDLE, bit counter=0, shift register=0.
- Registered outputs: every output is a function of registers only; no combinational path from input to output.
- State machine IDLE / SHIFT / GAP:
  - IDLE:
    - req_ready=1, demux_in=0, frame_active=0.
    - demux_sel holds the previous channel; it is 0 after reset.
    - On a rising edge with req_valid=1: capture data_in into the shift register and chan into demux_sel, clear the counter, go to SHIFT.
  - SHIFT:
    - req_ready=0, frame_active=1.
    - demux_in equals the shift register MSB.
    - Each edge shifts the register left by one (LSB filled with 0) and increments the counter.
    - After WIDTH cycles in SHIFT: go to GAP if GAP>0, else go to IDLE.
  - GAP:
    - req_ready=0, demux_in=0, frame_active=0, demux_sel held.
    - Stay GAP cycles, then go to IDLE.
- Latency and timing:
  - If the request is accepted at edge k, bit[WIDTH-1] is on demux_in in cycle k+1 and bit[0] in cycle k+WIDTH.
  - frame_done=1 in cycle k+WIDTH+1 only, whatever state that cycle falls in.
  - Minimum spacing between back-to-back acceptances is 1+WIDTH+GAP cycles.
- Select stability: demux_sel changes only at an acceptance edge. It never changes while frame_active=1 or during GAP.
- Ignored inputs: req_valid, data_in and chan are ignored while req_ready=0. There is no queuing; the requester must hold req_valid until it sees ready.
- Counter width: $clog2(WIDTH+1). The counter wraps to 0 on every acceptance; no overflow is possible.
- Reset during SHIFT or GAP:
  - The frame is abandoned and no frame_done is issued.
  - After rst_n rises, the block is in IDLE with req_ready=1 and accepts on the next edge that sees req_valid.
- Simultaneous events: frame_done and a new acceptance never coincide when GAP>0. When GAP=0, frame_done is high during the IDLE cycle, and a request may be accepted on that same cycle's closing edge.

Test Plan:
- Single frame (WIDTH=8, GAP=1): after reset, data_in=8'hA5, chan=2, req_valid for 1 cycle → demux_sel=2 from the cycle after acceptance; demux_in=1,0,1,0,0,1,0,1 over 8 cycles with frame_active=1; frame_done pulses once in the 9th cycle; req_ready returns high 10 cycles after acceptance.
- Back-to-back: req_valid held high with 8'hFF/chan=3, then switched to 8'h00/chan=1 on the first handshake → acceptances exactly 10 cycles apart; demux_sel stays 3 through the first frame and its gap, then becomes 1; demux_in=1 for 8 cycles, then 0.
- Request during busy: while a frame is in SHIFT, pulse req_valid with 8'h3C/chan=0 → request ignored; demux_sel and the bit sequence unaffected; no extra frame_done.
- Reset mid-frame: assert rst_n=0 at the 4th bit of 8'hC3/chan=1 → all outputs 0 immediately and req_ready=1 immediately; no frame_done; after release, a request with 8'h81/chan=2 produces the full sequence 1,0,0,0,0,0,0,1.
- Parameter corner (WIDTH=4, GAP=0): continuous req_valid with 4'h9/chan=0 → demux_in pattern 1,0,0,1 repeating with one idle cycle between frames; frame_done high in each idle cycle; acceptance period 5 cycles.
